// File: rtl/defuzz_pkg.sv
// Shared constants, FSM state type and divider-length helper for the centroid defuzzifier.
package defuzz_pkg;

    localparam int          FRAC_BITS = 12;
    localparam logic [31:0] Q_ONE     = 32'h1000;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        PREP,
        DIVIDE,
        DONE
    } defuzz_state_t;

    // One quotient bit per dividend bit; dividend is |wacc| pre-shifted by FRAC_BITS.
    function automatic int DIV_CYC(input int acc_w);
        return acc_w + FRAC_BITS;
    endfunction

endpackage

// File: rtl/defuzzify_centroid_if.sv
// Sample-in / crisp-out bus of the centroid defuzzifier; slave is the defuzzifier side.
interface defuzzify_centroid_if;

    logic        input_valid;
    logic [31:0] area_sum;
    logic [31:0] weighted_sum_of_centers;
    logic        in_ready;
    logic [31:0] crisp_out;
    logic        output_valid;
    logic        zero_area;
    logic        overrun;

    modport master (
        output input_valid, area_sum, weighted_sum_of_centers,
        input  in_ready, crisp_out, output_valid, zero_area, overrun
    );

    modport slave (
        input  input_valid, area_sum, weighted_sum_of_centers,
        output in_ready, crisp_out, output_valid, zero_area, overrun
    );

endinterface

// File: rtl/defuzzify_centroid_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the dividend register doubles as the quotient.
module seq_divider #(
    parameter int DVD_W = 60,
    parameter int DVS_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [CNT_W-1:0] remaining;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W:0]   shifted;
    logic [DVS_W+1:0] diff;

    always_comb begin
        shifted = {rem, quotient[DVD_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs};
    end

    // High during the final iteration so the caller can leave its wait state on the same edge.
    assign done = busy && (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            remaining <= '0;
            rem       <= '0;
            dvs       <= '0;
            quotient  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            remaining <= CNT_W'(DVD_W);
            rem       <= '0;
            dvs       <= divisor;
            quotient  <= dividend;
        end else if (busy) begin
            if (diff[DVS_W+1]) begin
                rem      <= shifted[DVS_W-1:0];
                quotient <= {quotient[DVD_W-2:0], 1'b0};
            end else begin
                rem      <= diff[DVS_W-1:0];
                quotient <= {quotient[DVD_W-2:0], 1'b1};
            end
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/defuzzify_centroid.sv
// Centroid defuzzifier: accumulates N_RULES samples, then crisp = sum(weighted)/sum(area) in Q.12.
// Define DEFUZZ_SAT_EN to saturate out-of-range quotients instead of truncating to 32 bits.
module defuzzify_centroid
    import defuzz_pkg::*;
#(
    parameter int                 N_RULES     = 9,
    parameter int                 ACC_W       = 48,
    parameter logic signed [31:0] DEFAULT_OUT = 32'sh0
) (
    input logic clk,
    input logic rst,
    defuzzify_centroid_if.slave bus
);

    localparam int         DVD_W = DIV_CYC(ACC_W);
    localparam logic [7:0] LAST  = 8'(N_RULES);

    defuzz_state_t           state;
    logic signed [ACC_W-1:0] wacc;
    logic signed [ACC_W-1:0] aacc;
    logic [7:0]              count;
    logic                    sign_r;
    logic                    zero_area_r;

    logic signed [ACC_W-1:0] area_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0]        abs_w;
    logic                    div_start;
    logic                    div_busy;
    logic                    div_done;
    logic [DVD_W-1:0]        quotient;
    logic [31:0]             narrowed;

    always_comb begin
        area_ext = {{(ACC_W-32){bus.area_sum[31]}}, bus.area_sum};
        w_ext    = {{(ACC_W-32){bus.weighted_sum_of_centers[31]}}, bus.weighted_sum_of_centers};
        abs_w    = wacc[ACC_W-1] ? -wacc : wacc;
    end

    assign div_start = (state == PREP) && !div_busy;

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (ACC_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({abs_w, {FRAC_BITS{1'b0}}}),
        .divisor  (aacc),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

`ifdef DEFUZZ_SAT_EN
    always_comb begin
        narrowed = sign_r ? -quotient[31:0] : quotient[31:0];
        if (|quotient[DVD_W-1:31]) narrowed = sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    logic unused_quot_hi;
    assign unused_quot_hi = ^quotient[DVD_W-1:32];
    always_comb narrowed = sign_r ? -quotient[31:0] : quotient[31:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wacc             <= '0;
            aacc             <= '0;
            count            <= '0;
            sign_r           <= 1'b0;
            zero_area_r      <= 1'b0;
            bus.in_ready     <= 1'b1;
            bus.crisp_out    <= '0;
            bus.output_valid <= 1'b0;
            bus.zero_area    <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.output_valid <= 1'b0;
            unique case (state)
                IDLE: if (bus.input_valid) begin
                    wacc  <= w_ext;
                    aacc  <= area_ext;
                    count <= 8'd1;
                    if (N_RULES == 1) begin
                        state        <= PREP;
                        bus.in_ready <= 1'b0;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (bus.input_valid) begin
                    wacc  <= wacc + w_ext;
                    aacc  <= aacc + area_ext;
                    count <= count + 8'd1;
                    if (count + 8'd1 == LAST) begin
                        state        <= PREP;
                        bus.in_ready <= 1'b0;
                    end
                end
                PREP: if (!div_busy) begin
                    sign_r      <= wacc[ACC_W-1];
                    zero_area_r <= (aacc <= 0);
                    state       <= DIVIDE;
                end
                DIVIDE: if (div_done) state <= DONE;
                DONE: begin
                    bus.crisp_out    <= zero_area_r ? DEFAULT_OUT : narrowed;
                    bus.zero_area    <= zero_area_r;
                    bus.output_valid <= 1'b1;
                    bus.in_ready     <= 1'b1;
                    wacc             <= '0;
                    aacc             <= '0;
                    count            <= '0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.input_valid && !bus.in_ready) bus.overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_defuzzify_centroid.sv
// Scoreboard bench: two defuzzifier instances (N_RULES=2 and N_RULES=1) against an arithmetic centroid model.
module tb_defuzzify_centroid;
    import defuzz_pkg::*;

    localparam int unsigned LAT = 62;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    defuzzify_centroid_if ifa ();
    defuzzify_centroid_if ifb ();

    defuzzify_centroid #(
        .N_RULES     (2),
        .ACC_W       (48),
        .DEFAULT_OUT (32'sh0000_1234)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    defuzzify_centroid #(
        .N_RULES     (1),
        .ACC_W       (48),
        .DEFAULT_OUT (32'sh0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    typedef struct {
        logic [31:0] crisp;
        logic        zero;
        int unsigned due;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [31:0] fa[0:7];
    logic [31:0] fw[0:7];

    function automatic exp_t model(longint asum, longint wsum, logic [31:0] dflt, int unsigned due);
        exp_t   e;
        longint m;
        longint r;
        e.due = due;
        if (asum <= 0) begin
            e.crisp = dflt;
            e.zero  = 1'b1;
        end else begin
            m = (wsum < 0) ? -wsum : wsum;
            m = (m * 4096) / asum;
            r = (wsum < 0) ? -m : m;
            e.crisp = r[31:0];
`ifdef DEFUZZ_SAT_EN
            if (m >= (longint'(1) << 31)) e.crisp = (wsum < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            e.zero = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.output_valid === 1'b1) begin
            if (sb_a.size() == 0) begin
                fail_bound("a_unexpected_valid");
            end else begin
                e = sb_a.pop_front();
                chk("a_crisp", ifa.crisp_out, e.crisp);
                chk("a_zero_area", 32'(ifa.zero_area), 32'(e.zero));
                chk("a_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ifb.output_valid === 1'b1) begin
            if (sb_b.size() == 0) begin
                fail_bound("b_unexpected_valid");
            end else begin
                e = sb_b.pop_front();
                chk("b_crisp", ifb.crisp_out, e.crisp);
                chk("b_zero_area", 32'(ifb.zero_area), 32'(e.zero));
                chk("b_latency", cyc, e.due);
            end
        end
    end

    task automatic drive(int sel, logic v, logic [31:0] a, logic [31:0] w);
        if (sel == 0) begin
            ifa.input_valid = v; ifa.area_sum = a; ifa.weighted_sum_of_centers = w;
        end else begin
            ifb.input_valid = v; ifb.area_sum = a; ifb.weighted_sum_of_centers = w;
        end
    endtask

    function automatic logic rdy(int sel);
        return (sel == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(int sel);
        int n = 0;
        while (!rdy(sel) && n < 200) begin
            step();
            n++;
        end
        if (!rdy(sel)) fail_bound("ready_timeout");
    endtask

    task automatic wait_drain(int sel);
        int n = 0;
        while (((sel == 0) ? sb_a.size() : sb_b.size()) != 0 && n < 300) begin
            step();
            n++;
        end
        if (((sel == 0) ? sb_a.size() : sb_b.size()) != 0) fail_bound("drain_timeout");
    endtask

    task automatic run_frame(int sel, int n, logic [31:0] dflt, int max_gap);
        longint asum = 0;
        longint wsum = 0;
        for (int i = 0; i < n; i++) begin
            wait_ready(sel);
            drive(sel, 1'b1, fa[i], fw[i]);
            asum += longint'($signed(fa[i]));
            wsum += longint'($signed(fw[i]));
            step();
            drive(sel, 1'b0, '0, '0);
            if (i == n - 1) begin
                if (sel == 0) sb_a.push_back(model(asum, wsum, dflt, cyc + LAT));
                else          sb_b.push_back(model(asum, wsum, dflt, cyc + LAT));
                chk("in_ready_drop", 32'(rdy(sel)), 32'd0);
            end else begin
                for (int g = $urandom_range(max_gap, 0); g > 0; g--) step();
            end
        end
    endtask

    task automatic chk_reset_a(string tag);
        chk({tag, "_crisp"}, ifa.crisp_out, 32'h0);
        chk({tag, "_valid"}, 32'(ifa.output_valid), 32'd0);
        chk({tag, "_zero"}, 32'(ifa.zero_area), 32'd0);
        chk({tag, "_overrun"}, 32'(ifa.overrun), 32'd0);
        chk({tag, "_ready"}, 32'(ifa.in_ready), 32'd1);
    endtask

    task automatic set_basic(logic neg);
        fa[0] = Q_ONE; fa[1] = Q_ONE;
        fw[0] = neg ? -32'h2000 : 32'h2000;
        fw[1] = neg ? -32'h6000 : 32'h6000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (3) step();
        chk_reset_a("reset");
        chk("reset_b_ready", 32'(ifb.in_ready), 32'd1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        set_basic(1'b0);
        run_frame(0, 2, 32'h1234, 0);
        wait_drain(0);
        chk("basic_value", ifa.crisp_out, 32'h0000_4000);

        set_basic(1'b1);
        run_frame(0, 2, 32'h1234, 2);
        wait_drain(0);
        chk("negative_value", ifa.crisp_out, 32'hFFFF_C000);

        fa[0] = '0; fa[1] = '0; fw[0] = 32'h2000; fw[1] = 32'h6000;
        run_frame(0, 2, 32'h1234, 1);
        wait_drain(0);
        chk("zero_area_value", ifa.crisp_out, 32'h0000_1234);
        chk("zero_area_flag", 32'(ifa.zero_area), 32'd1);

        chk("overrun_clear", 32'(ifa.overrun), 32'd0);
        set_basic(1'b0);
        run_frame(0, 2, 32'h1234, 0);
        repeat (10) step();
        drive(0, 1'b1, 32'h7FFF_0000, 32'h1234_5678);
        step();
        drive(0, 1'b0, '0, '0);
        chk("overrun_set", 32'(ifa.overrun), 32'd1);
        wait_drain(0);
        chk("overrun_frame_value", ifa.crisp_out, 32'h0000_4000);
        set_basic(1'b1);
        run_frame(0, 2, 32'h1234, 1);
        wait_drain(0);
        chk("overrun_sticky", 32'(ifa.overrun), 32'd1);

        set_basic(1'b0);
        run_frame(0, 2, 32'h1234, 0);
        repeat (31) step();
        rst_a = 1'b1;
        void'(sb_a.pop_back());
        step();
        rst_a = 1'b0;
        chk_reset_a("midrst");
        repeat (80) step();
        set_basic(1'b0);
        run_frame(0, 2, 32'h1234, 0);
        wait_drain(0);
        chk("post_reset_value", ifa.crisp_out, 32'h0000_4000);

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 2; i++) begin
                case ($urandom_range(3, 0))
                    0:       fa[i] = $urandom();
                    1:       fa[i] = -32'($urandom_range(16, 0));
                    default: fa[i] = 32'($urandom_range(32'h0004_0000, 1));
                endcase
                fw[i] = $urandom();
            end
            run_frame(0, 2, 32'h1234, 3);
        end
        wait_drain(0);

        fa[0] = 32'h0000_0001;
        fw[0] = 32'h7FFF_FFFF;
        run_frame(1, 1, 32'h0, 0);
        wait_drain(1);
`ifdef DEFUZZ_SAT_EN
        chk("saturation_value", ifb.crisp_out, 32'h7FFF_FFFF);
`else
        chk("saturation_value", ifb.crisp_out, 32'hFFFF_F000);
`endif
        for (int f = 0; f < 20; f++) begin
            fa[0] = ($urandom_range(4, 0) == 0) ? -32'($urandom_range(100, 0)) : 32'($urandom_range(32'h0010_0000, 1));
            fw[0] = $urandom();
            run_frame(1, 1, 32'h0, 0);
        end
        wait_drain(1);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/defuzzify_centroid.md
# defuzzify_centroid

Centroid defuzzifier that consumes the per-rule area / weighted-centre stream produced by the rule-weight stage and emits one crisp output per inference frame. It accumulates `N_RULES` samples, then runs a bit-serial signed division, crisp = Σweighted / Σarea in Q.12, and presents the result with a one-cycle valid pulse. It sits at the tail of the fuzzy inference pipeline, directly downstream of the weight calculation.

## Interface
Parameters:
- `N_RULES`, 9: samples per frame, range 1..255.
- `ACC_W`, 48: accumulator width in bits, signed.
- `DEFAULT_OUT`, 32'sh0: crisp value output when Σarea ≤ 0.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `input_valid`, input, 1: `area_sum` and `weighted_sum_of_centers` carry one rule sample.
- `area_sum`, input, 32: signed Q20.12 rule area.
- `weighted_sum_of_centers`, input, 32: signed Q20.12 centre×area.
- `in_ready`, output, 1: registered; high in IDLE and ACCUM.
- `crisp_out`, output, 32: signed Q20.12 result; holds its value until the next result.
- `output_valid`, output, 1: one-cycle pulse when `crisp_out` is updated.
- `zero_area`, output, 1: qualifies the current `crisp_out`; set when Σarea ≤ 0.
- `overrun`, output, 1: sticky; set when a sample arrives while `in_ready`=0.

## Operation
- The FSM has five states: IDLE, ACCUM, PREP, DIVIDE, DONE.
- **IDLE**
  - A valid sample loads the accumulators, `wacc` and `aacc`, with the sign-extended inputs and sets count=1.
  - The FSM moves to ACCUM, or directly to PREP when `N_RULES`=1.
- **ACCUM**
  - Each valid sample adds to both accumulators and increments count.
  - The sample that makes count=`N_RULES` moves the FSM to PREP.
  - Cycles without `input_valid` hold all state. There is no timeout.
- **PREP**
  - The divider loads dividend = |wacc| << 12 (width ACC_W+12) and divisor = aacc.
  - It captures sign = wacc[ACC_W-1].
  - It sets zero_area_r = (aacc ≤ 0).
- **DIVIDE**
  - Restoring division, one quotient bit per cycle.
  - Runs for DIV_CYC = ACC_W+12 cycles. With the defaults this is 60.
  - When Σarea ≤ 0 the divider still runs so that latency stays constant, and its result is discarded.
- **DONE**
  - Registers `crisp_out`, `zero_area` and the `output_valid` pulse.
  - Returns to IDLE and clears the accumulators and count.
- Result rules:
  - Quotient magnitude is truncated, so results round toward zero.
  - The sign is applied after division.
  - When zero_area_r=1 the result is `DEFAULT_OUT`.
  - The 32-bit narrowing follows `DEFUZZ_SAT_EN`.
- Overrun:
  - Samples with `input_valid`=1 in PREP, DIVIDE or DONE are dropped and set `overrun`.
  - A dropped sample never alters the frame in flight.
- Accumulators wrap silently at ACC_W bits. The defaults cannot wrap for 255 full-scale samples.

## Timing
- **Reset values:**
  - `crisp_out`=0, `output_valid`=0, `zero_area`=0, `overrun`=0, `in_ready`=1.
  - FSM in IDLE, accumulators and count at 0.
- **Reset mid-frame or mid-division:** the partial frame is discarded with no `output_valid`. The block accepts a new frame on the first cycle after `rst` falls.
- **Latency:** with the Nth sample sampled at edge E0:
  - PREP at E0+1.
  - DIVIDE over E0+2 .. E0+1+DIV_CYC.
  - DONE registers the result at E0+2+DIV_CYC.
  - `output_valid` is high for the cycle after that edge. With the defaults this is 62 edges after the Nth sample.
- **in_ready:** drops in the cycle after the Nth sample is accepted and rises again in the cycle after DONE.
- **Frame throughput:** a new frame's first sample is accepted in the IDLE cycle that follows DONE, so back-to-back frames have at least one ready cycle between them.

## Configuration
- `DEFUZZ_SAT_EN` defined:
  - A quotient magnitude ≥ 2^31 saturates the result.
  - Positive results saturate to 32'sh7FFFFFFF and negative results to 32'sh80000000.
- `DEFUZZ_SAT_EN` undefined:
  - The signed result is truncated to its low 32 bits.
  - No compare logic is generated.

## Structure
- **Package `defuzz_pkg`:** `FRAC_BITS`=12, `Q_ONE`=32'h1000, the FSM state enum `defuzz_state_t`, and the `DIV_CYC` function of `ACC_W`.
- **Sub-module `seq_divider`:** unsigned restoring divider.
  - Parameterised dividend and divisor widths.
  - Ports: `start`, `dividend`, `divisor`, `busy`, `done`, `quotient`.
  - `defuzzify_centroid` instantiates it once and owns sign, zero-area and saturation handling.

## Test plan
- **Basic frame:** `N_RULES`=2; samples (area 0x1000, w 0x2000) and (0x1000, 0x6000) → `crisp_out`=0x00004000, `zero_area`=0, `output_valid` exactly 62 edges after the second sample.
- **Negative sign:** same areas, w = −0x2000 and −0x6000 → `crisp_out`=0xFFFFC000 (truncation toward zero).
- **Zero area:** all areas 0, `DEFAULT_OUT`=0x00001234 → `crisp_out`=0x00001234, `zero_area`=1, latency unchanged.
- **Overrun:** pulse `input_valid` during DIVIDE → `overrun`=1 and stays 1; the frame result equals the basic-frame value; the next frame is correct.
- **Saturation:** `N_RULES`=1, area 0x00000001, w 0x7FFFFFFF → 0x7FFFFFFF with `DEFUZZ_SAT_EN`, 0xFFFFF000 without it.
- **Reset mid-operation:** assert `rst` at DIVIDE cycle 30 → no `output_valid`, all outputs at reset values, and a following basic frame yields 0x00004000.
